// File: rtl/pma_region_responder.sv
// Single-region register responder: 7 R/W words plus a free-running cycle counter.
// Build option: define PMA_RESP_REGION_ERR_EN to flag region misses with o_resp_err.
module pma_region_responder #(
    parameter logic [47:0] BAR  = 48'h000010000000,
    parameter logic [47:0] MASK = 48'h0000000fffff
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [47:0] i_req_addr,
    input  logic [63:0] i_req_wdata,
    input  logic [7:0]  i_req_wstrb,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [63:0] o_resp_rdata,
    output logic        o_resp_err
);

`ifdef PMA_RESP_REGION_ERR_EN
    localparam logic MISS_ERR = 1'b1;
`else
    localparam logic MISS_ERR = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        write_q;
    logic [47:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic [63:0] regs_q [7];
    logic [63:0] cnt_q;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [63:0] bank [8];
    logic [47:0] offset;
    logic [2:0]  word;
    logic        hit;
    logic        in_range;
    logic        reg_wr;

    assign offset   = addr_q & MASK;
    assign hit      = (addr_q & ~MASK) == BAR;
    assign in_range = hit && (offset < 48'h40);
    assign word     = addr_q[5:3];

    always_comb begin
        for (int i = 0; i < 7; i++) bank[i] = regs_q[i];
        bank[7] = cnt_q;
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        reg_wr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                rdata_d = '0;
                err_d   = 1'b0;
                if (!hit) begin
                    err_d = MISS_ERR;
                end else if (in_range) begin
                    // Word 7 is the counter: reads see it, writes fall on the floor.
                    if (write_q) reg_wr = (word != 3'd7);
                    else         rdata_d = bank[word];
                end
            end
            ST_RESP: begin
                if (i_resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_q + 64'd1;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the register words are architecturally visible after reset and must
    // clear, so this small bank is reset explicitly rather than left to RAM.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 7; i++) regs_q[i] <= '0;
        end else if (reg_wr) begin
            for (int i = 0; i < 7; i++) begin
                if (word == i[2:0]) begin
                    for (int b = 0; b < 8; b++) begin
                        if (wstrb_q[b]) regs_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

    // NOTE: captured request fields are only consumed after a valid capture,
    // so they carry no reset.
    always_ff @(posedge i_clk) begin
        if (state_q == ST_IDLE && i_req_valid) begin
            write_q <= i_req_write;
            addr_q  <= i_req_addr;
            wdata_q <= i_req_wdata;
            wstrb_q <= i_req_wstrb;
        end
    end

    assign o_req_ready  = (state_q == ST_IDLE);
    assign o_resp_valid = (state_q == ST_RESP);
    assign o_resp_rdata = rdata_q;
    assign o_resp_err   = err_q;

endmodule

// File: tb/tb_pma_region_responder.sv
// Scoreboard bench for pma_region_responder: driver pushes model expectations,
// monitor pops and compares on every response handshake.
module tb_pma_region_responder;

    localparam logic [47:0] BAR  = 48'h000010000000;
    localparam logic [47:0] MASK = 48'h0000000fffff;
`ifdef PMA_RESP_REGION_ERR_EN
    localparam logic MISS_ERR = 1'b1;
`else
    localparam logic MISS_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [47:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;

    pma_region_responder #(.BAR(BAR), .MASK(MASK)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_write (req_write),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .i_req_wstrb (req_wstrb),
        .o_resp_valid(resp_valid),
        .i_resp_ready(resp_ready),
        .o_resp_rdata(resp_rdata),
        .o_resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } resp_t;

    resp_t       sb_q[$];
    logic [63:0] mdl [8];
    int unsigned reset_edge = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: region decode, byte-merge writes, counter = cycles since reset.
    function automatic resp_t model(input bit wr, input logic [47:0] a, input logic [63:0] d,
                                    input logic [7:0] s, input int unsigned acc_edge);
        resp_t       r;
        logic [47:0] off;
        int          idx;
        r.rdata = '0;
        r.err   = 1'b0;
        off     = a & MASK;
        if ((a & ~MASK) != BAR) begin
            r.err = MISS_ERR;
        end else if (off < 48'd64) begin
            idx = int'(off) / 8;
            if (idx == 7) begin
                if (!wr) r.rdata = 64'(acc_edge - reset_edge);
            end else if (wr) begin
                for (int b = 0; b < 8; b++)
                    if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
            end else begin
                r.rdata = mdl[idx];
            end
        end
        return r;
    endfunction

    // Monitor: a handshake is seen when valid and ready are both up mid-cycle.
    initial begin
        forever begin
            resp_t e;
            @(negedge clk);
            #2;
            if (resp_valid && resp_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got rdata %h err %b, expected none", resp_rdata, resp_err);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", 64'(resp_err), 64'(e.err));
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        reset_edge = cyc + 1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_rdata", resp_rdata, 64'd0);
        check("rst_err", 64'(resp_err), 64'd0);
    endtask

    task automatic xact(input bit wr, input logic [47:0] a, input logic [63:0] d,
                        input logic [7:0] s, input int hold, input bit offer,
                        output int unsigned acc_edge);
        int w;
        acc_edge = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got req_ready 0, expected 1 within 20 cycles");
            req_valid = 1'b0;
            return;
        end
        acc_edge = cyc + 1;
        sb_q.push_back(model(wr, a, d, s, acc_edge));
        @(negedge clk);
        req_valid = 1'b0;
        req_write = $urandom_range(0, 1);
        req_addr  = {$urandom, $urandom} & 48'hffff_ffff_ffff;
        req_wdata = {$urandom, $urandom};
        check("access_resp_valid", 64'(resp_valid), 64'd0);
        check("access_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("resp_valid_rise", 64'(resp_valid), 64'd1);
        if (offer) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = BAR;
            req_wdata = 64'hdead_beef_dead_beef;
            req_wstrb = 8'hff;
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_resp_valid", 64'(resp_valid), 64'd1);
            check("hold_req_ready", 64'(req_ready), 64'd0);
            check("hold_rdata", resp_rdata, sb_q[sb_q.size() - 1].rdata);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("post_resp_valid", 64'(resp_valid), 64'd0);
        check("post_req_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned a1;
        int unsigned a_tmp;
        do_reset();

        // Full write then read back, then partial-strobe merge.
        xact(1, BAR + 48'h08, 64'h1122334455667788, 8'hff, 0, 0, a_tmp);
        xact(0, BAR + 48'h08, '0, 8'h00, 0, 0, a_tmp);
        xact(1, BAR + 48'h08, 64'haaaaaaaaaaaaaaaa, 8'h0f, 0, 0, a_tmp);
        xact(0, BAR + 48'h08, '0, 8'h00, 0, 0, a_tmp);

        // Stalled response with a competing request offered; word 0 must stay 0.
        xact(0, BAR + 48'h08, '0, 8'h00, 5, 1, a_tmp);
        xact(0, BAR, '0, 8'h00, 0, 0, a_tmp);

        // Counter reads ten cycles apart, then an ignored write to it.
        xact(0, BAR + 48'h38, '0, 8'h00, 0, 0, a1);
        while (cyc + 1 < a1 + 9) @(negedge clk);
        xact(0, BAR + 48'h38, '0, 8'h00, 0, 0, a_tmp);
        xact(1, BAR + 48'h38, 64'h0, 8'hff, 0, 0, a_tmp);
        xact(0, BAR + 48'h3f, '0, 8'h00, 1, 0, a_tmp);

        // Zero-strobe write, out-of-window hits, region misses.
        xact(1, BAR + 48'h10, 64'h0123456789abcdef, 8'h00, 0, 0, a_tmp);
        xact(0, BAR + 48'h10, '0, 8'h00, 0, 0, a_tmp);
        xact(1, BAR + 48'h40, 64'hffffffffffffffff, 8'hff, 0, 0, a_tmp);
        xact(0, BAR + 48'h40, '0, 8'h00, 0, 0, a_tmp);
        xact(0, 48'h000020000000, '0, 8'h00, 0, 0, a_tmp);
        xact(1, 48'h000020000008, 64'h5555555555555555, 8'hff, 0, 0, a_tmp);
        xact(1, BAR + 48'h100, 64'h7777777777777777, 8'hff, 0, 0, a_tmp);
        xact(0, BAR + 48'h08, '0, 8'h00, 0, 0, a_tmp);
        xact(0, BAR + 48'h00, '0, 8'h00, 0, 0, a_tmp);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            logic [47:0] a;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 48'h000020000000 | 48'($urandom_range(0, 63));
            else if (sel == 1) a = BAR | 48'($urandom_range(64, 4095));
            else               a = BAR | 48'($urandom_range(0, 63));
            xact(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), a_tmp);
        end

        // Reset while a write response is pending: response dropped, words cleared.
        xact(1, BAR + 48'h18, 64'hcafef00dcafef00d, 8'hff, 0, 0, a_tmp);
        @(negedge clk);
        check("rst_test_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = BAR + 48'h20;
        req_wdata = 64'h0badc0de0badc0de;
        req_wstrb = 8'hff;
        a_tmp = cyc + 1;
        sb_q.push_back(model(1, req_addr, req_wdata, req_wstrb, a_tmp));
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_test_in_resp", 64'(resp_valid), 64'd1);
        rst = 1'b1;
        reset_edge = cyc + 1;
        void'(sb_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        check("rst_drop_valid", 64'(resp_valid), 64'd0);
        check("rst_drop_rdata", resp_rdata, 64'd0);
        for (int i = 0; i < 8; i++)
            xact(0, BAR + 48'(8 * i), '0, 8'h00, 0, 0, a_tmp);

        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending responses, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
